flit_time_stamper: RTL



---
 rtl/flit_time_stamper.sv | 89 ++++++++
 1 files changed

// File: rtl/flit_time_stamper.sv
// flit_time_stamper: injection-side stamping buffer between a PE and a router.
// Each accepted flit is tagged with a nonzero injection time from a
// free-running counter that skips 0 and the all-ones sentinel. Tagged flits
// are queued in a small circular FIFO and presented to the router in order.

module flit_time_stamper #(
   parameter int WIDTH_TIME = 8,
   parameter int WIDTH_DATA = 64,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pe_valid,
   input  logic [WIDTH_DATA-1:0]    pe_data,
   output logic                     pe_ready,
   output logic                     inj_valid,
   output logic [WIDTH_DATA-1:0]    inj_data,
   output logic [WIDTH_TIME-1:0]    inj_time,
   input  logic                     inj_grant,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Time 0 means "no flit" downstream and all-ones is a sentinel, so the
   // counter runs 1 .. MAX_TIME-1 and wraps back to 1.
   localparam logic [WIDTH_TIME-1:0] FIRST_TIME = WIDTH_TIME'(1);
   localparam logic [WIDTH_TIME-1:0] LAST_TIME  = {WIDTH_TIME{1'b1}} - WIDTH_TIME'(1);
   localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(DEPTH);

   logic [WIDTH_DATA-1:0] mem_data [DEPTH];
   logic [WIDTH_TIME-1:0] mem_time [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [WIDTH_TIME-1:0] cur_time;
   logic                  push;
   logic                  pop;

   // Handshake terms come only from registered occupancy and reset, so there
   // is no combinational path from pe_valid or inj_grant to pe_ready.
   assign pe_ready  = (count < FULL_CNT) && !reset;
   assign inj_valid = (count != '0);
   assign push      = pe_valid && pe_ready;
   assign pop       = inj_valid && inj_grant;

   // Head entry, forced to zero when empty so a stale entry never looks valid.
   assign inj_data = inj_valid ? mem_data[rd_ptr] : '0;
   assign inj_time = inj_valid ? mem_time[rd_ptr] : '0;

   // Free-running injection clock: 1, 2, ..., MAX_TIME-1, 1, ...
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_time <= FIRST_TIME;
      end else if (cur_time == LAST_TIME) begin
         cur_time <= FIRST_TIME;
      end else begin
         cur_time <= cur_time + WIDTH_TIME'(1);
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage: payload plus the time stamp sampled in the push cycle.
   // NOTE: storage is deliberately not reset; occupancy alone decides validity,
   // and leaving the array unreset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= pe_data;
         mem_time[wr_ptr] <= cur_time;
      end
   end

endmodule
